// File: rtl/cpu_bus_if.sv
// cpu_bus_if: control strobes, memory data and debug taps between the sequencer and the cpu_bus datapath
interface cpu_bus_if;
  logic        PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0]  AND;
  logic        R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
  logic        R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic [31:0] Mdatain;
  logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
  logic [31:0] BusMuxOut, MAR_q, IR_q, ZLow_q, R5_q;
  modport master (
    output PCout, ZHighout, Zlowout, MDRout, R2out, R4out, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, AND,
           R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
           Mdatain, HIin, LOin, ZHighIn, ZLowIn, Cin,
    input  BusMuxOut, MAR_q, IR_q, ZLow_q, R5_q
  );
  modport slave (
    input  PCout, ZHighout, Zlowout, MDRout, R2out, R4out, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, AND,
           R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
           Mdatain, HIin, LOin, ZHighIn, ZLowIn, Cin,
    output BusMuxOut, MAR_q, IR_q, ZLow_q, R5_q
  );
endinterface

// File: rtl/cpu_bus.sv
// cpu_bus: 32-bit single-bus datapath (register file, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, ALU) stepped by an external sequencer
module cpu_bus (
  input logic       Clock,
  input logic       Clear,
  cpu_bus_if.slave  bus
);
  logic [31:0] r_rf [1:15];
  logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo;
  logic [63:0] r_z;
  logic [31:0] w_bus;
  logic [14:0] w_rin;
  logic [63:0] w_c, w_prod, w_rotr, w_rotl;
  logic signed [31:0] w_ds, w_quo, w_rem;
  assign w_rin = {bus.R15in, bus.R14in, bus.R13in, bus.R12in, bus.R11in, bus.R10in, bus.R9in, bus.R8in,
                  bus.R7in, bus.R6in, bus.R5in, bus.R4in, bus.R3in, bus.R2in, bus.R1in};
  assign w_bus = bus.PCout    ? r_pc       :
                 bus.ZHighout ? r_z[63:32] :
                 bus.Zlowout  ? r_z[31:0]  :
                 bus.MDRout   ? r_mdr      :
                 bus.R2out    ? r_rf[2]    :
                 bus.R4out    ? r_rf[4]    : 32'h0;
  assign w_prod = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});
  assign w_rotr = {r_y, r_y} >> w_bus[4:0];
  assign w_rotl = {r_y, r_y} << w_bus[4:0];
  // divisor forced to 1 on zero so the divider never sees x; the result is discarded anyway
  assign w_ds   = (w_bus == 32'h0) ? 32'sd1 : $signed(w_bus);
  assign w_quo  = $signed(r_y) / w_ds;
  assign w_rem  = $signed(r_y) % w_ds;
  always_comb begin
    w_c = '0;
    case (bus.AND)
      5'b00011: w_c[31:0] = r_y + w_bus + {31'd0, bus.Cin};
      5'b00100: w_c[31:0] = r_y - w_bus;
      5'b00101: w_c[31:0] = r_y >> w_bus[4:0];
      5'b00110: w_c[31:0] = r_y << w_bus[4:0];
      5'b00111: w_c[31:0] = w_rotr[31:0];
      5'b01000: w_c[31:0] = w_rotl[63:32];
      5'b01001: w_c[31:0] = r_y & w_bus;
      5'b01010: w_c[31:0] = r_y | w_bus;
      5'b01111: w_c = w_prod;
      5'b10000: w_c = (w_bus == 32'h0) ? 64'h0 : {w_rem, w_quo};
      5'b10001: w_c[31:0] = -w_bus;
      5'b10010: w_c[31:0] = ~w_bus;
      default:  w_c = '0;
    endcase
  end
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 1; i < 16; i++) r_rf[i] <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      for (int i = 1; i < 16; i++) if (w_rin[i-1]) r_rf[i] <= w_bus;
      if (bus.IncPC) r_pc <= r_pc + 32'd1;
      else if (bus.PCin) r_pc <= w_bus;
      if (bus.IRin)    r_ir       <= w_bus;
      if (bus.MARin)   r_mar      <= w_bus;
      if (bus.MDRin)   r_mdr      <= bus.Read ? bus.Mdatain : w_bus;
      if (bus.Yin)     r_y        <= w_bus;
      if (bus.ZLowIn)  r_z[31:0]  <= w_c[31:0];
      if (bus.ZHighIn) r_z[63:32] <= w_c[63:32];
      if (bus.HIin)    r_hi       <= w_bus;
      if (bus.LOin)    r_lo       <= w_bus;
    end
  end
  assign bus.BusMuxOut = w_bus;
  assign bus.MAR_q     = r_mar;
  assign bus.IR_q      = r_ir;
  assign bus.ZLow_q    = r_z[31:0];
  assign bus.R5_q      = r_rf[5];
endmodule

// File: tb/tb_cpu_bus.sv
// tb_cpu_bus: directed vector table plus reset sequences for cpu_bus
module tb_cpu_bus;
  logic clk = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cpu_bus_if b ();
  cpu_bus dut (.Clock(clk), .Clear(clear), .bus(b.slave));

  localparam logic [21:0] PCO = 22'd1 << 0,  ZHO = 22'd1 << 1,  ZLO = 22'd1 << 2,  MDO = 22'd1 << 3;
  localparam logic [21:0] R2O = 22'd1 << 4,  R4O = 22'd1 << 5,  MARI = 22'd1 << 6, PCI = 22'd1 << 7;
  localparam logic [21:0] MDI = 22'd1 << 8,  IRI = 22'd1 << 9,  YI = 22'd1 << 10,  INC = 22'd1 << 11;
  localparam logic [21:0] RD = 22'd1 << 12,  HII = 22'd1 << 13, LOI = 22'd1 << 14, ZHI = 22'd1 << 15;
  localparam logic [21:0] ZLI = 22'd1 << 16, R2I = 22'd1 << 17, R4I = 22'd1 << 18, R5I = 22'd1 << 19;
  localparam logic [21:0] R1I = 22'd1 << 20, CIN = 22'd1 << 21;

  typedef struct {
    logic [21:0] ctl;
    logic [4:0]  op;
    logic [31:0] din;
    int          sel;
    logic [31:0] exp;
  } vec_t;
  vec_t v[$];
  logic [31:0] bus_pre;

  function automatic void add(logic [21:0] c, logic [4:0] op, logic [31:0] d, int sel, logic [31:0] e);
    v.push_back('{c, op, d, sel, e});
  endfunction
  function automatic void ld(logic [31:0] d);
    add(RD | MDI, 5'd0, d, 1, 32'h0);
  endfunction

  task automatic drive(input logic [21:0] c, input logic [4:0] op, input logic [31:0] d, input logic rest);
    b.PCout = c[0];  b.ZHighout = c[1]; b.Zlowout = c[2]; b.MDRout = c[3]; b.R2out = c[4]; b.R4out = c[5];
    b.MARin = c[6];  b.PCin = c[7];     b.MDRin = c[8];   b.IRin = c[9];   b.Yin = c[10];  b.IncPC = c[11];
    b.Read = c[12];  b.HIin = c[13];    b.LOin = c[14];   b.ZHighIn = c[15]; b.ZLowIn = c[16];
    b.R2in = c[17];  b.R4in = c[18];    b.R5in = c[19];   b.R1in = c[20];  b.Cin = c[21];
    b.R3in = rest; b.R6in = rest; b.R7in = rest; b.R8in = rest; b.R9in = rest; b.R10in = rest;
    b.R11in = rest; b.R12in = rest; b.R13in = rest; b.R14in = rest; b.R15in = rest;
    b.AND = op; b.Mdatain = d;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, " bus"}, b.BusMuxOut, 32'h0);
    chk({n, " mar"}, b.MAR_q, 32'h0);
    chk({n, " ir"}, b.IR_q, 32'h0);
    chk({n, " zlow"}, b.ZLow_q, 32'h0);
    chk({n, " r5"}, b.R5_q, 32'h0);
  endtask

  initial begin
    ld(32'h22); add(MDO | R2I, 0, 0, 1, 32'h22);
    ld(32'h24); add(MDO | R4I, 0, 0, 1, 32'h24);
    ld(32'h26); add(MDO | R5I, 0, 0, 5, 32'h26);
    add(R2O | YI, 0, 0, 1, 32'h22);
    add(R4O | ZLI, 5'b01001, 0, 4, 32'h20);
    add(ZLO | R5I, 0, 0, 5, 32'h20);
    add(PCO | MARI | INC, 0, 0, 2, 32'h0);
    add(PCO, 0, 0, 1, 32'h1);
    ld(32'h4A920000); add(MDO | IRI, 0, 0, 3, 32'h4A920000);
    ld(32'h7); add(PCO | MDO, 0, 0, 1, 32'h1);
    add(22'h0, 0, 0, 1, 32'h0);
    add(MDO | PCI | INC, 0, 0, 1, 32'h7); add(PCO, 0, 0, 1, 32'h2);
    add(MDO | PCI, 0, 0, 1, 32'h7); add(PCO, 0, 0, 1, 32'h7);
    ld(32'hFFFFFFFF); add(MDO | YI, 0, 0, 1, 32'hFFFFFFFF);
    ld(32'h1); add(MDO | ZLI | ZHI, 5'b00011, 0, 4, 32'h0); add(ZHO, 0, 0, 1, 32'h0);
    add(MDO | ZLI | CIN, 5'b00011, 0, 4, 32'h1);
    ld(32'hFFFFFFFE); add(MDO | YI, 0, 0, 1, 32'hFFFFFFFE);
    ld(32'h3); add(MDO | ZLI | ZHI, 5'b01111, 0, 4, 32'hFFFFFFFA); add(ZHO, 0, 0, 1, 32'hFFFFFFFF);
    ld(32'h7); add(MDO | YI, 0, 0, 1, 32'h7);
    ld(32'h0); add(MDO | ZLI | ZHI, 5'b10000, 0, 4, 32'h0); add(ZHO, 0, 0, 1, 32'h0);
    ld(32'hFFFFFFFE); add(MDO | ZLI | ZHI, 5'b10000, 0, 4, 32'hFFFFFFFD); add(ZHO, 0, 0, 1, 32'h1);
    ld(32'h80000001); add(MDO | YI, 0, 0, 1, 32'h80000001);
    ld(32'h1); add(MDO | ZLI | ZHI, 5'b01000, 0, 4, 32'h3); add(ZHO, 0, 0, 1, 32'h0);
    add(MDO | ZLI, 5'b00111, 0, 4, 32'hC0000000);
    add(MDO | ZLI, 5'b00101, 0, 4, 32'h40000000);
    add(MDO | ZLI, 5'b00110, 0, 4, 32'h2);
    add(MDO | ZLI, 5'b00100, 0, 4, 32'h80000000);
    add(MDO | ZLI, 5'b10001, 0, 4, 32'hFFFFFFFF);
    add(MDO | ZLI, 5'b10010, 0, 4, 32'hFFFFFFFE);
    add(MDO | ZLI, 5'b11111, 0, 4, 32'h0);
    add(MDO | ZLI, 5'b01010, 0, 4, 32'h80000001);

    drive(22'h3FFFFF, 5'b01111, 32'hFFFFFFFF, 1'b1);
    #1 chk_all_zero("reset0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 chk_all_zero("reset_hold");
    end
    @(negedge clk);
    drive(22'h0, 5'd0, 32'h0, 1'b0);
    clear = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      drive(v[i].ctl, v[i].op, v[i].din, 1'b0);
      #1 bus_pre = b.BusMuxOut;
      @(posedge clk); #1;
      case (v[i].sel)
        1: chk($sformatf("vec%0d bus", i), bus_pre, v[i].exp);
        2: chk($sformatf("vec%0d mar", i), b.MAR_q, v[i].exp);
        3: chk($sformatf("vec%0d ir", i), b.IR_q, v[i].exp);
        4: chk($sformatf("vec%0d zlow", i), b.ZLow_q, v[i].exp);
        5: chk($sformatf("vec%0d r5", i), b.R5_q, v[i].exp);
        default: ;
      endcase
    end

    @(negedge clk);
    drive(ZLO, 5'd0, 32'h0, 1'b0);
    #1 chk("pre_midreset bus", b.BusMuxOut, 32'h80000001);
    #1 clear = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk); #1 chk_all_zero("midreset_hold");
    @(negedge clk); clear = 1'b1;
    drive(22'h0, 5'd0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
